// File: rtl/traffic_phase_ctrl_if.sv
// Control/lamp bundle for the traffic phase controller.
// Master side drives sensors, requests and reprogram strobes; slave is the controller.
interface traffic_phase_ctrl_if #(
  parameter int NUM_PHASES = 2,
  parameter int TW         = 4
);
  logic                  tick;
  logic [NUM_PHASES-1:0] Sync_Sensor;
  logic [NUM_PHASES-1:0] WalkReq;
  logic                  Sync_Reprogram;
  logic [1:0]            prog_sel;
  logic [TW-1:0]         prog_val;
  logic [NUM_PHASES-1:0] green;
  logic [NUM_PHASES-1:0] yellow;
  logic [NUM_PHASES-1:0] red;
  logic [NUM_PHASES-1:0] walk;
  logic [NUM_PHASES-1:0] WalkReg_Reset;
  logic [2:0]            phase;
  logic [2:0]            state;
  logic [TW-1:0]         remaining;

  modport master (
    output tick, Sync_Sensor, WalkReq,
    output Sync_Reprogram, prog_sel, prog_val,
    input  green, yellow, red, walk,
    input  WalkReg_Reset, phase, state, remaining
  );

  modport slave (
    input  tick, Sync_Sensor, WalkReq,
    input  Sync_Reprogram, prog_sel, prog_val,
    output green, yellow, red, walk,
    output WalkReg_Reset, phase, state, remaining
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Round-robin N-approach traffic light sequencer with per-state interval timer,
// latched walk requests and run-time programmable intervals.
module traffic_phase_ctrl #(
  parameter int NUM_PHASES = 2,
  parameter int TW         = 4,
  parameter int BASE_DEF   = 6,
  parameter int EXT_DEF    = 3,
  parameter int YEL_DEF    = 2,
  parameter int WALK_DEF   = 3
) (
  input logic clk,
  input logic Sync_Reset,
  traffic_phase_ctrl_if.slave bus
);
  localparam logic [2:0] GRN    = 3'd0;
  localparam logic [2:0] EXT    = 3'd1;
  localparam logic [2:0] YEL    = 3'd2;
  localparam logic [2:0] WALK   = 3'd3;
  localparam logic [2:0] ALLRED = 3'd4;
  localparam int         NP     = NUM_PHASES;

  logic [2:0]    state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [TW-1:0] rem_q, rem_d;
  logic [TW-1:0] base_q, base_d;
  logic [TW-1:0] ext_q, ext_d;
  logic [TW-1:0] yel_q, yel_d;
  logic [TW-1:0] wlk_q, wlk_d;
  logic [NP-1:0] pend_q, pend_d;
  logic [NP-1:0] green_q, green_d;
  logic [NP-1:0] yellow_q, yellow_d;
  logic [NP-1:0] red_q, red_d;
  logic [NP-1:0] walk_q, walk_d;
  logic [NP-1:0] wrr_q, wrr_d;
  logic [NP-1:0] cur_oh, nxt_oh, clr;
  logic [2:0]    phase_inc;
  logic          expire;

  function automatic logic [TW-1:0] nz(input logic [TW-1:0] v);
    return (v == '0) ? TW'(1) : v;
  endfunction

  assign cur_oh    = NP'(1) << phase_q;
  assign expire    = bus.tick && (rem_q == TW'(1));
  assign phase_inc = (phase_q >= 3'(NP - 1)) ? 3'd0 : phase_q + 3'd1;

  always_ff @(posedge clk) begin
    if (Sync_Reset) begin
      state_q  <= GRN;
      phase_q  <= 3'd0;
      rem_q    <= TW'(BASE_DEF);
      base_q   <= TW'(BASE_DEF);
      ext_q    <= TW'(EXT_DEF);
      yel_q    <= TW'(YEL_DEF);
      wlk_q    <= TW'(WALK_DEF);
      pend_q   <= '0;
      green_q  <= NP'(1);
      yellow_q <= '0;
      red_q    <= ~NP'(1);
      walk_q   <= '0;
      wrr_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      rem_q    <= rem_d;
      base_q   <= base_d;
      ext_q    <= ext_d;
      yel_q    <= yel_d;
      wlk_q    <= wlk_d;
      pend_q   <= pend_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
      walk_q   <= walk_d;
      wrr_q    <= wrr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = bus.tick ? rem_q - TW'(1) : rem_q;
    base_d  = base_q;
    ext_d   = ext_q;
    yel_d   = yel_q;
    wlk_d   = wlk_q;
    clr     = '0;
    if (bus.Sync_Reprogram) begin
      unique case (bus.prog_sel)
        2'd0: base_d = bus.prog_val;
        2'd1: ext_d  = bus.prog_val;
        2'd2: yel_d  = bus.prog_val;
        2'd3: wlk_d  = bus.prog_val;
      endcase
      state_d = GRN;
      phase_d = 3'd0;
      rem_d   = nz(base_d);
    end else begin
      case (state_q)
        GRN: if (expire) begin
          if (|(bus.Sync_Sensor & cur_oh)) begin
            state_d = EXT;
            rem_d   = nz(ext_q);
          end else begin
            state_d = YEL;
            rem_d   = nz(yel_q);
          end
        end
        EXT: if (expire) begin
          state_d = YEL;
          rem_d   = nz(yel_q);
        end
        YEL: if (expire) begin
          if (|(pend_q & cur_oh)) begin
            state_d = WALK;
            rem_d   = nz(wlk_q);
            clr     = cur_oh;
          end else begin
            state_d = ALLRED;
            rem_d   = TW'(1);
          end
        end
        WALK, ALLRED: if (expire) begin
          state_d = GRN;
          phase_d = phase_inc;
          rem_d   = nz(base_q);
        end
        default: begin
          state_d = GRN;
          phase_d = 3'd0;
          rem_d   = nz(base_q);
        end
      endcase
    end
    // a request arriving in the clearing cycle stays pending
    pend_d = (pend_q & ~clr) | bus.WalkReq;
    wrr_d  = clr;
  end

  always_comb begin
    nxt_oh   = NP'(1) << phase_d;
    green_d  = '0;
    yellow_d = '0;
    walk_d   = '0;
    unique case (1'b1)
      (state_d == GRN),
      (state_d == EXT):  green_d  = nxt_oh;
      (state_d == YEL):  yellow_d = nxt_oh;
      (state_d == WALK): walk_d   = nxt_oh;
      default: ;
    endcase
    red_d = ~(green_d | yellow_d);
  end

  assign bus.green         = green_q;
  assign bus.yellow        = yellow_q;
  assign bus.red           = red_q;
  assign bus.walk          = walk_q;
  assign bus.WalkReg_Reset = wrr_q;
  assign bus.phase         = phase_q;
  assign bus.state         = state_q;
  assign bus.remaining     = rem_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: NUM_PHASES=2, defaults,
// one tick per four clocks.
module tb_traffic_phase_ctrl;
  logic clk = 1'b0;
  logic Sync_Reset;
  int   total = 0;
  int   bad   = 0;

  traffic_phase_ctrl_if #(.NUM_PHASES(2), .TW(4)) bus ();

  traffic_phase_ctrl #(
    .NUM_PHASES(2), .TW(4), .BASE_DEF(6),
    .EXT_DEF(3), .YEL_DEF(2), .WALK_DEF(3)
  ) dut (
    .clk(clk),
    .Sync_Reset(Sync_Reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b0;
      repeat (3) clk1();
      bus.tick = 1'b1;
      clk1();
      bus.tick = 1'b0;
    end
  endtask

  task automatic st(input string tag, input int ph,
                    input int s, input int r);
    chk({tag, ".phase"}, bus.phase, ph);
    chk({tag, ".state"}, bus.state, s);
    chk({tag, ".rem"}, bus.remaining, r);
  endtask

  task automatic lamps(input string tag, input int g,
                       input int y, input int r, input int w);
    chk({tag, ".green"}, bus.green, g);
    chk({tag, ".yellow"}, bus.yellow, y);
    chk({tag, ".red"}, bus.red, r);
    chk({tag, ".walk"}, bus.walk, w);
  endtask

  initial begin
    Sync_Reset         = 1'b1;
    bus.tick           = 1'b0;
    bus.Sync_Sensor    = '0;
    bus.WalkReq        = '0;
    bus.Sync_Reprogram = 1'b0;
    bus.prog_sel       = '0;
    bus.prog_val       = '0;
    clk1();
    clk1();
    Sync_Reset = 1'b0;

    st("rst", 0, 0, 6);
    lamps("rst", 1, 0, 2, 0);
    chk("rst.wrr", bus.WalkReg_Reset, 0);

    // plain cycle
    tk(5);
    st("g0_last", 0, 0, 1);
    tk(1);
    st("y0", 0, 2, 2);
    lamps("y0", 0, 1, 2, 0);
    tk(2);
    st("ar0", 0, 4, 1);
    lamps("ar0", 0, 0, 3, 0);
    tk(1);
    st("g1", 1, 0, 6);
    lamps("g1", 2, 0, 1, 0);
    tk(9);
    st("wrap", 0, 0, 6);

    // sensor extension, only once
    bus.Sync_Sensor = 2'b01;
    tk(6);
    st("ext", 0, 1, 3);
    lamps("ext", 1, 0, 2, 0);
    tk(3);
    st("ext_y", 0, 2, 2);
    bus.Sync_Sensor = 2'b00;

    // walk request for phase 1
    bus.WalkReq = 2'b10;
    clk1();
    bus.WalkReq = 2'b00;
    tk(2);
    st("p0_noWalk", 0, 4, 1);
    tk(7);
    st("y1", 1, 2, 2);
    tk(2);
    st("walk1", 1, 3, 3);
    lamps("walk1", 0, 0, 3, 2);
    chk("walk1.wrr", bus.WalkReg_Reset, 2);
    clk1();
    chk("walk1.wrr_off", bus.WalkReg_Reset, 0);
    tk(3);
    st("after_walk", 0, 0, 6);
    tk(9 + 8);
    st("p1_allred", 1, 4, 1);

    // reprogram base=2 mid-yellow of phase 1, coincident tick
    tk(1 + 9 + 6);
    st("y1b", 1, 2, 2);
    repeat (3) clk1();
    bus.tick           = 1'b1;
    bus.Sync_Reprogram = 1'b1;
    bus.prog_sel       = 2'd0;
    bus.prog_val       = 4'd2;
    clk1();
    bus.tick           = 1'b0;
    bus.Sync_Reprogram = 1'b0;
    st("reprog", 0, 0, 2);
    lamps("reprog", 1, 0, 2, 0);
    tk(2);
    st("reprog_y", 0, 2, 2);

    // yellow programmed to 0 behaves as 1 tick
    bus.Sync_Reprogram = 1'b1;
    bus.prog_sel       = 2'd2;
    bus.prog_val       = 4'd0;
    clk1();
    bus.Sync_Reprogram = 1'b0;
    st("y0prog", 0, 0, 2);
    tk(2);
    st("y_one", 0, 2, 1);
    tk(1);
    st("y_one_ar", 0, 4, 1);

    // reset mid-walk clears pending requests and intervals
    bus.WalkReq = 2'b01;
    clk1();
    bus.WalkReq = 2'b00;
    tk(1 + 2 + 1 + 1 + 2 + 1);
    st("walk0", 0, 3, 3);
    lamps("walk0", 0, 0, 3, 1);
    bus.WalkReq = 2'b10;
    clk1();
    bus.WalkReq = 2'b00;
    tk(1);
    Sync_Reset = 1'b1;
    clk1();
    Sync_Reset = 1'b0;
    st("rst2", 0, 0, 6);
    lamps("rst2", 1, 0, 2, 0);
    chk("rst2.wrr", bus.WalkReg_Reset, 0);
    tk(6);
    st("rst2_y", 0, 2, 2);
    tk(2 + 1 + 6 + 2);
    st("rst2_nopend", 1, 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
